// File: rtl/branch_predict_unit.sv
// Decode-side branch predictor: gshare BHT of saturating counters plus a circular
// return address stack with checkpoint restore for mispredict recovery.
module branch_predict_unit #(
   parameter int BP_ADDR_BITS = 12,
   parameter int BH_BITS      = 9,
   parameter int CTR_BITS     = 2,
   parameter int RAS_DEPTH    = 8,
   localparam int PW = $clog2(RAS_DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    D_stall_i,
   input  logic                    D_flush_i,
   input  logic                    D_valid_i,
   input  logic [31:0]             D_PC_i,
   input  logic                    D_isBranch_i,
   input  logic                    D_isJAL_i,
   input  logic                    D_isJALR_i,
   input  logic [4:0]              D_rdId_i,
   input  logic [4:0]              D_rs1Id_i,
   input  logic [31:0]             D_Bimm_i,
   input  logic [31:0]             D_Jimm_i,
   output logic                    D_predictPC_o,
   output logic [31:0]             D_PCprediction_o,
   output logic                    D_predictBranch_o,
   output logic [BP_ADDR_BITS-1:0] D_bhtIndex_o,
   output logic [PW-1:0]           D_rasPtr_o,
   output logic [CW-1:0]           D_rasCount_o,
   input  logic                    E_stall_i,
   input  logic                    E_isBranch_i,
   input  logic                    E_takeBranch_i,
   input  logic [BP_ADDR_BITS-1:0] E_bhtIndex_i,
   input  logic                    E_mispredict_i,
   input  logic [PW-1:0]           E_rasPtr_i,
   input  logic [CW-1:0]           E_rasCount_i,
   output logic                    ready_o
);

   localparam int BHT_SIZE = 1 << BP_ADDR_BITS;
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

   typedef enum logic {INIT, RUN} bpState_t;

   bpState_t                stateReg;
   bpState_t                stateNext;
   logic [BP_ADDR_BITS-1:0] initIdx;
   logic [BH_BITS-1:0]      history;

   logic [CTR_BITS-1:0]     bht [BHT_SIZE];
   logic                    bhtWe;
   logic [BP_ADDR_BITS-1:0] bhtWAddr;
   logic [CTR_BITS-1:0]     bhtWData;
   logic [BP_ADDR_BITS-1:0] bhtIndex;
   logic [CTR_BITS-1:0]     bhtRead;
   logic [CTR_BITS-1:0]     updCtr;
   logic [CTR_BITS-1:0]     updCtrNext;
   logic                    bhtUpdate;

   logic [31:0]             ras [RAS_DEPTH];
   logic [PW-1:0]           rasPtr;
   logic [CW-1:0]           rasCount;
   logic [PW-1:0]           rasPtrInc;
   logic                    rdLink;
   logic                    rs1Link;
   logic                    rasEnable;
   logic                    isCoroutine;
   logic                    isPush;
   logic                    isPop;
   logic [31:0]             linkAddr;

   // ---------------- BHT initialisation FSM ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stateReg <= INIT;
         initIdx  <= '0;
      end else begin
         stateReg <= stateNext;
         if (stateReg == INIT)
            initIdx <= initIdx + BP_ADDR_BITS'(1);
      end
   end

   always_comb begin
      stateNext = stateReg;
      if (stateReg == INIT && initIdx == BP_ADDR_BITS'(BHT_SIZE - 1))
         stateNext = RUN;
   end

   // INIT owns the single BHT write port; in RUN it carries resolved-branch updates
   always_comb begin
      ready_o  = (stateReg == RUN);
      bhtWe    = 1'b0;
      bhtWAddr = E_bhtIndex_i;
      bhtWData = updCtrNext;
      if (stateReg == INIT) begin
         bhtWe    = 1'b1;
         bhtWAddr = initIdx;
         bhtWData = CTR_WNT;
      end else if (bhtUpdate) begin
         bhtWe    = 1'b1;
      end
   end

   // ---------------- gshare BHT ----------------
   assign bhtIndex  = D_PC_i[BP_ADDR_BITS+1:2] ^ (BP_ADDR_BITS'(history) << (BP_ADDR_BITS - BH_BITS));
   assign bhtRead   = bht[bhtIndex];
   assign bhtUpdate = (stateReg == RUN) && E_isBranch_i && !E_stall_i;
   assign updCtr    = bht[E_bhtIndex_i];

   always_comb begin
      updCtrNext = updCtr;
      if (E_takeBranch_i) begin
         if (updCtr != CTR_MAX)
            updCtrNext = updCtr + CTR_BITS'(1);
      end else begin
         if (updCtr != '0)
            updCtrNext = updCtr - CTR_BITS'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (bhtWe)
         bht[bhtWAddr] <= bhtWData;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         history <= '0;
      else if (bhtUpdate)
         history <= (history >> 1) | (BH_BITS'(E_takeBranch_i) << (BH_BITS - 1));
   end

   assign D_bhtIndex_o      = bhtIndex;
   assign D_predictBranch_o = (stateReg == RUN) && bhtRead[CTR_BITS-1];

   // ---------------- Return address stack ----------------
   assign rdLink      = (D_rdId_i == 5'd1) || (D_rdId_i == 5'd5);
   assign rs1Link     = (D_rs1Id_i == 5'd1) || (D_rs1Id_i == 5'd5);
   assign rasEnable   = D_valid_i && !D_stall_i && !D_flush_i && !E_mispredict_i;
   assign isCoroutine = D_isJALR_i && rdLink && rs1Link && (D_rdId_i != D_rs1Id_i);
   assign isPush      = (D_isJAL_i || D_isJALR_i) && rdLink && !isCoroutine;
   assign isPop       = D_isJALR_i && (D_rdId_i == 5'd0) && rs1Link;
   assign linkAddr    = D_PC_i + 32'd4;
   assign rasPtrInc   = rasPtr + PW'(1);

   // A full stack keeps wrapping the pointer, so a push silently replaces the oldest entry
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rasPtr   <= '0;
         rasCount <= '0;
      end else if (E_mispredict_i) begin
         rasPtr   <= E_rasPtr_i;
         rasCount <= E_rasCount_i;
      end else if (rasEnable) begin
         if (isPush) begin
            rasPtr <= rasPtrInc;
            if (rasCount != CW'(RAS_DEPTH))
               rasCount <= rasCount + CW'(1);
         end else if (isPop && rasCount != '0) begin
            rasPtr   <= rasPtr - PW'(1);
            rasCount <= rasCount - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && rasEnable) begin
         if (isPush)
            ras[rasPtrInc] <= linkAddr;
         else if (isCoroutine)
            ras[rasPtr] <= linkAddr;
      end
   end

   assign D_rasPtr_o   = rasPtr;
   assign D_rasCount_o = rasCount;

   // ---------------- Next-PC prediction ----------------
   always_comb begin
      D_predictPC_o    = 1'b0;
      D_PCprediction_o = D_PC_i + D_Bimm_i;
      if (D_valid_i) begin
         if (D_isJAL_i) begin
            D_predictPC_o    = 1'b1;
            D_PCprediction_o = D_PC_i + D_Jimm_i;
         end else if (D_isJALR_i) begin
            D_predictPC_o    = (rasCount != '0);
            D_PCprediction_o = ras[rasPtr];
         end else if (D_isBranch_i) begin
            D_predictPC_o    = D_predictBranch_o;
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised and directed checks of branch_predict_unit against a behavioural
// model of the BHT counters, global history and return stack.
module tb_branch_predict_unit;

   localparam int AB  = 4;
   localparam int HB  = 3;
   localparam int CB  = 2;
   localparam int RD  = 4;
   localparam int PW  = 2;
   localparam int CW  = 3;
   localparam int BHT = 1 << AB;
   localparam int CMAX = (1 << CB) - 1;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          D_stall_i, D_flush_i, D_valid_i;
   logic [31:0]   D_PC_i;
   logic          D_isBranch_i, D_isJAL_i, D_isJALR_i;
   logic [4:0]    D_rdId_i, D_rs1Id_i;
   logic [31:0]   D_Bimm_i, D_Jimm_i;
   logic          D_predictPC_o;
   logic [31:0]   D_PCprediction_o;
   logic          D_predictBranch_o;
   logic [AB-1:0] D_bhtIndex_o;
   logic [PW-1:0] D_rasPtr_o;
   logic [CW-1:0] D_rasCount_o;
   logic          E_stall_i, E_isBranch_i, E_takeBranch_i;
   logic [AB-1:0] E_bhtIndex_i;
   logic          E_mispredict_i;
   logic [PW-1:0] E_rasPtr_i;
   logic [CW-1:0] E_rasCount_i;
   logic          ready_o;

   branch_predict_unit #(
      .BP_ADDR_BITS(AB), .BH_BITS(HB), .CTR_BITS(CB), .RAS_DEPTH(RD)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .D_stall_i(D_stall_i), .D_flush_i(D_flush_i), .D_valid_i(D_valid_i),
      .D_PC_i(D_PC_i), .D_isBranch_i(D_isBranch_i), .D_isJAL_i(D_isJAL_i),
      .D_isJALR_i(D_isJALR_i), .D_rdId_i(D_rdId_i), .D_rs1Id_i(D_rs1Id_i),
      .D_Bimm_i(D_Bimm_i), .D_Jimm_i(D_Jimm_i),
      .D_predictPC_o(D_predictPC_o), .D_PCprediction_o(D_PCprediction_o),
      .D_predictBranch_o(D_predictBranch_o), .D_bhtIndex_o(D_bhtIndex_o),
      .D_rasPtr_o(D_rasPtr_o), .D_rasCount_o(D_rasCount_o),
      .E_stall_i(E_stall_i), .E_isBranch_i(E_isBranch_i),
      .E_takeBranch_i(E_takeBranch_i), .E_bhtIndex_i(E_bhtIndex_i),
      .E_mispredict_i(E_mispredict_i), .E_rasPtr_i(E_rasPtr_i),
      .E_rasCount_i(E_rasCount_i), .ready_o(ready_o)
   );

   always #5 clk_i = ~clk_i;

   int nTests = 0;
   int nFail  = 0;

   // behavioural reference state
   int          mBht [BHT];
   int          mHist, mPtr, mCnt, mInitCnt;
   bit          mReady;
   logic [31:0] mRas [RD];
   int          ckP, ckC;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int modelIdx();
      return int'(D_PC_i[AB+1:2]) ^ ((mHist << (AB - HB)) % BHT);
   endfunction

   function automatic bit isLink(input logic [4:0] id);
      return (id == 5'd1) || (id == 5'd5);
   endfunction

   task automatic modelCheck();
      int          idx;
      bit          predBr, expPred;
      logic [31:0] expTgt;
      idx     = modelIdx();
      predBr  = mReady && (mBht[idx] >= (1 << (CB - 1)));
      expPred = 1'b0;
      expTgt  = 32'h0;
      if (D_valid_i) begin
         if (D_isJAL_i) begin
            expPred = 1'b1;
            expTgt  = D_PC_i + D_Jimm_i;
         end else if (D_isJALR_i) begin
            expPred = (mCnt > 0);
            expTgt  = mRas[mPtr];
         end else if (D_isBranch_i) begin
            expPred = predBr;
            expTgt  = D_PC_i + D_Bimm_i;
         end
      end
      check("ready", ready_o, mReady);
      check("bhtIndex", D_bhtIndex_o, idx);
      check("predictBranch", D_predictBranch_o, predBr);
      check("rasPtr", D_rasPtr_o, mPtr);
      check("rasCount", D_rasCount_o, mCnt);
      check("predictPC", D_predictPC_o, expPred);
      if (expPred)
         check("target", D_PCprediction_o, expTgt);
   endtask

   // Applies the spec rules for one clock edge using the inputs present before it
   task automatic modelEdge();
      bit rdL, rs1L, cor, push, pop;
      int e;
      if (reset_i) begin
         mHist = 0; mPtr = 0; mCnt = 0; mReady = 1'b0; mInitCnt = 0;
      end else begin
         if (!mReady) begin
            mInitCnt++;
            if (mInitCnt == BHT) begin
               mReady = 1'b1;
               for (int i = 0; i < BHT; i++) mBht[i] = (1 << (CB - 1)) - 1;
            end
         end else if (E_isBranch_i && !E_stall_i) begin
            e = int'(E_bhtIndex_i);
            if (E_takeBranch_i) mBht[e] = (mBht[e] == CMAX) ? CMAX : mBht[e] + 1;
            else                mBht[e] = (mBht[e] == 0) ? 0 : mBht[e] - 1;
            mHist = (mHist >> 1) | (int'(E_takeBranch_i) << (HB - 1));
         end
         if (E_mispredict_i) begin
            mPtr = int'(E_rasPtr_i);
            mCnt = int'(E_rasCount_i);
         end else if (D_valid_i && !D_stall_i && !D_flush_i) begin
            rdL  = isLink(D_rdId_i);
            rs1L = isLink(D_rs1Id_i);
            cor  = D_isJALR_i && rdL && rs1L && (D_rdId_i != D_rs1Id_i);
            push = (D_isJAL_i || D_isJALR_i) && rdL && !cor;
            pop  = D_isJALR_i && (D_rdId_i == 5'd0) && rs1L;
            if (push) begin
               mPtr = (mPtr + 1) % RD;
               mRas[mPtr] = D_PC_i + 32'd4;
               mCnt = (mCnt == RD) ? RD : mCnt + 1;
            end else if (cor) begin
               mRas[mPtr] = D_PC_i + 32'd4;
            end else if (pop && mCnt > 0) begin
               mPtr = (mPtr + RD - 1) % RD;
               mCnt = mCnt - 1;
            end
         end
      end
   endtask

   task automatic cycle();
      #2;
      modelCheck();
      @(posedge clk_i);
      modelEdge();
      #1;
   endtask

   task automatic idle();
      D_stall_i = 0; D_flush_i = 0; D_valid_i = 0; D_PC_i = 0;
      D_isBranch_i = 0; D_isJAL_i = 0; D_isJALR_i = 0;
      D_rdId_i = 0; D_rs1Id_i = 0; D_Bimm_i = 0; D_Jimm_i = 0;
      E_stall_i = 0; E_isBranch_i = 0; E_takeBranch_i = 0; E_bhtIndex_i = 0;
      E_mispredict_i = 0; E_rasPtr_i = 0; E_rasCount_i = 0;
   endtask

   task automatic dec(input logic br, input logic jal, input logic jalr, input logic [31:0] pc,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
      D_valid_i = 1; D_isBranch_i = br; D_isJAL_i = jal; D_isJALR_i = jalr;
      D_PC_i = pc; D_rdId_i = rd; D_rs1Id_i = rs1; D_Bimm_i = imm; D_Jimm_i = imm;
   endtask

   function automatic logic [4:0] pickReg();
      case ($urandom_range(0, 3))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd5;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      int          expPre [4];
      logic [31:0] pc5;
      int          cls;
      expPre = '{0, 1, 1, 1};
      ckP = 0; ckC = 0;
      idle();
      reset_i = 1;
      @(posedge clk_i);
      modelEdge();
      #1;
      cycle();
      reset_i = 0;

      // initialisation length and weakly-not-taken contents
      for (int k = 0; k < BHT; k++) begin
         #2; check("readyLow", ready_o, 0);
         cycle();
      end
      #2; check("readyHigh", ready_o, 1);
      cycle();
      for (int i = 0; i < BHT; i++) begin
         dec(1, 0, 0, 32'(i << 2), 0, 0, 32'h8);
         #2; check("bhtInitNT", D_predictBranch_o, 0);
         cycle();
      end
      idle();

      // counter saturation at index 5 with same-cycle reads seeing the old value
      for (int k = 0; k < 4; k++) begin
         E_isBranch_i = 1; E_takeBranch_i = (k < 3); E_bhtIndex_i = 4'd5;
         pc5 = 32'h1000 | 32'((5 ^ ((mHist << 1) % BHT)) << 2);
         dec(1, 0, 0, pc5, 0, 0, 32'h20);
         #2;
         check("bhtNoBypass", D_predictBranch_o, expPre[k]);
         check("bhtIdx5", D_bhtIndex_o, 5);
         cycle();
      end
      idle();
      pc5 = 32'h1000 | 32'((5 ^ ((mHist << 1) % BHT)) << 2);
      dec(1, 0, 0, pc5, 0, 0, 32'h20);
      #2; check("bhtAfterNT", D_predictBranch_o, 1);
      cycle();

      // call then return, then return on empty stack
      dec(0, 1, 0, 32'h100, 1, 0, 32'h40);
      #2; check("jalTarget", D_PCprediction_o, 32'h140);
      cycle();
      dec(0, 0, 1, 32'h140, 0, 1, 0);
      #2; check("retPred", D_predictPC_o, 1); check("retTarget", D_PCprediction_o, 32'h104);
      cycle();
      dec(0, 0, 1, 32'h144, 0, 1, 0);
      #2; check("emptyCount", D_rasCount_o, 0); check("emptyNoPred", D_predictPC_o, 0);
      cycle();

      // overflow: five calls into a four-entry stack
      for (int k = 1; k <= 5; k++) begin
         dec(0, 1, 0, 32'(k << 4), 1, 0, 32'h800);
         cycle();
      end
      for (int k = 5; k >= 1; k--) begin
         dec(0, 0, 1, 32'h900, 0, 5, 0);
         #2;
         if (k == 5) check("fullCount", D_rasCount_o, 4);
         if (k > 1) check("ovfRetTarget", D_PCprediction_o, 32'((k << 4) + 4));
         else       check("ovfRetNoPred", D_predictPC_o, 0);
         cycle();
      end

      // checkpoint, two more calls, restore with a simultaneous call that must be dropped
      dec(0, 1, 0, 32'h300, 1, 0, 32'h10); cycle();
      dec(0, 1, 0, 32'h310, 1, 0, 32'h10); cycle();
      ckP = mPtr; ckC = mCnt;
      dec(0, 1, 0, 32'h320, 1, 0, 32'h10); cycle();
      dec(0, 1, 0, 32'h330, 1, 0, 32'h10); cycle();
      E_mispredict_i = 1; E_rasPtr_i = PW'(ckP); E_rasCount_i = CW'(ckC);
      dec(0, 1, 0, 32'h340, 1, 0, 32'h10);
      cycle();
      idle();
      dec(0, 0, 1, 32'h500, 0, 1, 0);
      #2;
      check("restorePtr", D_rasPtr_o, 3);
      check("restoreCount", D_rasCount_o, 2);
      check("restoreTarget", D_PCprediction_o, 32'h314);
      cycle();

      // coroutine swap then stalled call
      dec(0, 0, 1, 32'h200, 1, 5, 0); cycle();
      dec(0, 0, 1, 32'h600, 0, 1, 0);
      #2; check("coTarget", D_PCprediction_o, 32'h204); check("coCount", D_rasCount_o, 1);
      cycle();
      dec(0, 1, 0, 32'h400, 1, 0, 32'h10); D_stall_i = 1; cycle();
      D_stall_i = 0;
      dec(0, 0, 1, 32'h610, 0, 1, 0);
      #2; check("stallCount", D_rasCount_o, 0); check("stallPtr", D_rasPtr_o, 1);
      cycle();

      // randomised traffic against the model
      for (int n = 0; n < 2000; n++) begin
         idle();
         reset_i = ($urandom_range(0, 699) == 0);
         cls = $urandom_range(0, 3);
         D_valid_i = ($urandom_range(0, 9) != 0);
         D_isBranch_i = (cls == 1); D_isJAL_i = (cls == 2); D_isJALR_i = (cls == 3);
         D_PC_i = $urandom & 32'hFFFF_FFFC;
         D_rdId_i = pickReg(); D_rs1Id_i = pickReg();
         D_Bimm_i = $urandom; D_Jimm_i = $urandom;
         D_stall_i = ($urandom_range(0, 9) == 0);
         D_flush_i = ($urandom_range(0, 9) == 0);
         E_stall_i = ($urandom_range(0, 6) == 0);
         E_isBranch_i = $urandom_range(0, 1);
         E_takeBranch_i = $urandom_range(0, 1);
         E_bhtIndex_i = AB'($urandom_range(0, BHT - 1));
         E_mispredict_i = ($urandom_range(0, 19) == 0);
         E_rasPtr_i = PW'(ckP); E_rasCount_i = CW'(ckC);
         if ($urandom_range(0, 4) == 0) begin ckP = mPtr; ckC = mCnt; end
         cycle();
      end
      reset_i = 0;
      idle();
      cycle();

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
